// File: rtl/sd_block_responder.sv
// Responder side of the sd_lba/sd_rd/sd_wr/sd_ack sector protocol: serves 512-byte
// sectors for VDNUM drives out of a byte-wide backing store, one byte per memory request.
//
// state   | meaning
// IDLE    | waiting for a drive request, round-robin grant
// RD_REQ  | fetch current byte (mem_rd until mem_ready, or zero when out of range)
// RD_PUT  | sd_buff_wr strobe for the fetched byte
// WR_ADDR | present sd_buff_addr to the initiator buffer
// WR_CAP  | capture initiator data, launch mem_wr
// WR_REQ  | wait for mem_ready (skipped when out of range)
// DONE    | drop sd_ack
// GAP     | one extra ack-low cycle before the next grant
module sd_block_responder #(
    parameter int VDNUM  = 2,
    parameter int MEM_AW = 24
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [32*VDNUM-1:0]   sd_lba,
    input  logic [VDNUM-1:0]      sd_rd,
    input  logic [VDNUM-1:0]      sd_wr,
    output logic [VDNUM-1:0]      sd_ack,
    output logic [8:0]            sd_buff_addr,
    output logic [7:0]            sd_buff_dout,
    input  logic [8*VDNUM-1:0]    sd_buff_din,
    output logic                  sd_buff_wr,
    input  logic [32*VDNUM-1:0]   img_blocks,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [7:0]            mem_din,
    input  logic [7:0]            mem_dout,
    input  logic                  mem_ready
);

    localparam int DEVW = (VDNUM > 1) ? $clog2(VDNUM) : 1;
    localparam int LBAW = MEM_AW - DEVW - 9;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_CAP, WR_REQ, DONE, GAP
    } state_t;

    state_t            state_q, state_d;
    logic [DEVW-1:0]   drive_q, drive_d;
    logic [DEVW-1:0]   ptr_q, ptr_d;
    logic [LBAW-1:0]   lba_q, lba_d;
    logic              oor_q, oor_d;
    logic [8:0]        byte_q, byte_d;
    logic [7:0]        dout_q, dout_d;
    logic [VDNUM-1:0]  ack_q, ack_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_din_q, mem_din_d;

    logic [VDNUM-1:0]  pending;
    logic              gnt_vld;
    int                gnt_idx;
    logic [31:0]       sel_lba;
    logic [31:0]       sel_blk;
    logic [MEM_AW-1:0] cur_addr;
    logic              last_byte;

    assign pending   = sd_rd | sd_wr;
    assign cur_addr  = {drive_q, lba_q, byte_q};
    assign last_byte = (byte_q == 9'd511);

    // Scan starts one past the last served drive so a held request cannot starve the others.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 0;
        for (int i = 1; i <= VDNUM; i++) begin
            if (!gnt_vld && pending[(int'(ptr_q) + i) % VDNUM]) begin
                gnt_vld = 1'b1;
                gnt_idx = (int'(ptr_q) + i) % VDNUM;
            end
        end
    end

    assign sel_lba = sd_lba[gnt_idx*32 +: 32];
    assign sel_blk = img_blocks[gnt_idx*32 +: 32];

    always_comb begin
        state_d    = state_q;
        drive_d    = drive_q;
        ptr_d      = ptr_q;
        lba_d      = lba_q;
        oor_d      = oor_q;
        byte_d     = byte_q;
        dout_d     = dout_q;
        ack_d      = ack_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    drive_d = DEVW'(gnt_idx);
                    ptr_d   = DEVW'(gnt_idx);
                    lba_d   = sel_lba[LBAW-1:0];
                    oor_d   = (sel_lba >= sel_blk);
                    byte_d  = 9'd0;
                    ack_d   = VDNUM'(1) << gnt_idx;
                    state_d = sd_rd[gnt_idx] ? RD_REQ : WR_ADDR;
                end
            end
            RD_REQ: begin
                if (oor_q) begin
                    dout_d  = 8'h00;
                    state_d = RD_PUT;
                end else if (mem_rd_q && mem_ready) begin
                    dout_d   = mem_dout;
                    mem_rd_d = 1'b0;
                    state_d  = RD_PUT;
                end else begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = cur_addr;
                end
            end
            RD_PUT: begin
                if (last_byte) begin
                    state_d = DONE;
                end else begin
                    byte_d  = byte_q + 9'd1;
                    state_d = RD_REQ;
                end
            end
            WR_ADDR: begin
                state_d = WR_CAP;
            end
            WR_CAP: begin
                // Initiator buffer is registered: data for sd_buff_addr arrives one cycle late.
                mem_din_d = sd_buff_din[int'(drive_q)*8 +: 8];
                if (!oor_q) begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = cur_addr;
                end
                state_d = WR_REQ;
            end
            WR_REQ: begin
                if (oor_q || (mem_wr_q && mem_ready)) begin
                    mem_wr_d = 1'b0;
                    if (last_byte) begin
                        state_d = DONE;
                    end else begin
                        byte_d  = byte_q + 9'd1;
                        state_d = WR_ADDR;
                    end
                end
            end
            DONE: begin
                ack_d   = '0;
                byte_d  = 9'd0;
                state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            drive_q    <= '0;
            ptr_q      <= '0;
            lba_q      <= '0;
            oor_q      <= 1'b0;
            byte_q     <= 9'd0;
            dout_q     <= 8'h00;
            ack_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            drive_q    <= drive_d;
            ptr_q      <= ptr_d;
            lba_q      <= lba_d;
            oor_q      <= oor_d;
            byte_q     <= byte_d;
            dout_q     <= dout_d;
            ack_q      <= ack_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = byte_q;
    assign sd_buff_dout = dout_q;
    assign sd_buff_wr   = (state_q == RD_PUT);
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign mem_wr       = mem_wr_q;
    assign mem_din      = mem_din_q;

endmodule

// File: tb/tb_sd_block_responder.sv
// Bench for sd_block_responder: table of sector transfers, hand-written multi-sector,
// arbitration and reset sequences, and random sectors against a byte-store model.
module tb_sd_block_responder;

    localparam int VDNUM   = 2;
    localparam int MEM_AW  = 24;
    localparam int RGN     = 1 << (MEM_AW - 1);
    localparam int LBA_MOD = RGN / 512;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] sd_lba = '0;
    logic [1:0]  sd_rd = '0;
    logic [1:0]  sd_wr = '0;
    logic [1:0]  sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [15:0] sd_buff_din;
    logic        sd_buff_wr;
    logic [63:0] img_blocks = '0;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = 8'h00;
    logic        mem_ready = 1'b0;

    always #5 clk_sys = ~clk_sys;

    sd_block_responder #(.VDNUM(VDNUM), .MEM_AW(MEM_AW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
        .img_blocks(img_blocks),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ready(mem_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Backing store (what the DUT talks to) and the bench's prediction of it.
    logic [7:0] store [int];
    logic [7:0] refm  [int];
    logic [7:0] wpat  [VDNUM];

    function automatic logic [7:0] preload(int a);
        return a[7:0] ^ a[16:9];
    endfunction

    function automatic logic [7:0] store_get(int a);
        if (store.exists(a)) return store[a];
        return preload(a);
    endfunction

    function automatic logic [7:0] ref_get(int a);
        if (refm.exists(a)) return refm[a];
        return preload(a);
    endfunction

    function automatic int reg_addr(int drv, int unsigned lba, int i);
        return drv * RGN + int'(lba % LBA_MOD) * 512 + i;
    endfunction

    typedef struct { int addr; logic [7:0] data; } wlog_t;
    typedef struct { logic [8:0] a; logic [7:0] d; } strb_t;
    wlog_t wlog[$];
    strb_t strb[$];
    int    max_lat  = 0;
    int    wait_cnt = 0;
    int    rd_done  = 0;
    int    multi_ack = 0;

    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            if (!reset_n) begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_rd || mem_wr) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    if (mem_rd) begin
                        mem_dout = store_get(int'(mem_addr));
                        rd_done++;
                    end else begin
                        store[int'(mem_addr)] = mem_din;
                        wlog.push_back('{int'(mem_addr), mem_din});
                    end
                    mem_ready = 1'b1;
                    wait_cnt  = int'($urandom_range(max_lat));
                end
            end
        end
    end

    // Initiator buffer: registered read port, data one cycle after the address.
    always @(posedge clk_sys) begin
        for (int n = 0; n < VDNUM; n++) sd_buff_din[8*n +: 8] <= wpat[n] ^ sd_buff_addr[7:0];
    end

    always @(negedge clk_sys) begin
        if (sd_buff_wr) strb.push_back('{sd_buff_addr, sd_buff_dout});
        if ($countones(sd_ack) > 1) multi_ack++;
    end

    task automatic wait_ack(input int drv, input bit level, input int limit,
                            output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b1;
        while (sd_ack[drv] !== level) begin
            @(negedge clk_sys);
            cycles++;
            if (cycles > limit) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    function automatic int rd_bad(int off, int drv, int unsigned lba, bit oor);
        int bad = 0;
        logic [7:0] e;
        for (int i = 0; i < 512; i++) begin
            e = oor ? 8'h00 : ref_get(reg_addr(drv, lba, i));
            if (off + i >= strb.size()) bad++;
            else if (strb[off+i].a != 9'(i) || strb[off+i].d !== e) bad++;
        end
        return bad;
    endfunction

    function automatic int wlog_bad(int drv, int unsigned lba);
        int bad = 0;
        for (int i = 0; i < wlog.size(); i++) begin
            if (wlog[i].addr != reg_addr(drv, lba, i) || wlog[i].data !== (wpat[drv] ^ i[7:0])) bad++;
        end
        return bad;
    endfunction

    function automatic void ref_write(int drv, int unsigned lba);
        for (int i = 0; i < 512; i++) refm[reg_addr(drv, lba, i)] = wpat[drv] ^ i[7:0];
    endfunction

    task automatic run_sector(input string name, input int drv, input bit rd, input bit wr,
                              input int unsigned lba, input int unsigned blk,
                              input int e_strb, input int e_rd, input int e_wr,
                              output int ack_len);
        bit oor;
        bit ok;
        oor = (lba >= blk);
        strb.delete();
        wlog.delete();
        rd_done = 0;
        @(negedge clk_sys);
        sd_lba[32*drv +: 32]     = lba;
        img_blocks[32*drv +: 32] = blk;
        sd_rd[drv] = rd;
        sd_wr[drv] = wr;
        @(negedge clk_sys);
        check({name, ".ack_rise"}, sd_ack, 1 << drv);
        sd_rd[drv] = 1'b0;
        sd_wr[drv] = 1'b0;
        wait_ack(drv, 1'b0, 4000, ack_len, ok);
        check({name, ".ack_fall"}, ok, 1);
        repeat (3) @(negedge clk_sys);
        check({name, ".strobes"}, strb.size(), e_strb);
        check({name, ".mem_reads"}, rd_done, e_rd);
        check({name, ".mem_writes"}, wlog.size(), e_wr);
        if (rd) check({name, ".rd_data"}, rd_bad(0, drv, lba, oor), 0);
        else begin
            check({name, ".wr_log"}, wlog_bad(drv, lba), 0);
            if (!oor) ref_write(drv, lba);
        end
    endtask

    typedef struct {
        string name; int drv; bit rd; bit wr; int unsigned lba; int unsigned blk;
        int e_strb; int e_rd; int e_wr;
    } vec_t;
    vec_t vt[$];

    initial begin
        int len, cyc, pulses, min_gap, bad, found;
        bit ok, ok_all;

        #200000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, cyc, pulses, min_gap, bad, found;
        bit ok, ok_all;

        wpat[0] = 8'h3C;
        wpat[1] = 8'hA5;
        vt.push_back('{"rd_d0_lba3",   0, 1'b1, 1'b0, 3,            16,           512, 512, 0});
        vt.push_back('{"wr_d1_lba5",   1, 1'b0, 1'b1, 5,            16,           0,   0,   512});
        vt.push_back('{"rd_d0_oor",    0, 1'b1, 1'b0, 20,           16,           512, 0,   0});
        vt.push_back('{"wr_d0_oor",    0, 1'b0, 1'b1, 20,           16,           0,   0,   0});
        vt.push_back('{"rd_d1_back",   1, 1'b1, 1'b0, 5,            16,           512, 512, 0});
        vt.push_back('{"rd_d0_last",   0, 1'b1, 1'b0, 15,           16,           512, 512, 0});
        vt.push_back('{"rd_d0_edge",   0, 1'b1, 1'b0, 16,           16,           512, 0,   0});
        vt.push_back('{"rd_d1_unmnt",  1, 1'b1, 1'b0, 0,            0,            512, 0,   0});
        vt.push_back('{"rd_d1_hibits", 1, 1'b1, 1'b0, 32'h0100_0002, 32'hFFFF_FFFF, 512, 512, 0});
        vt.push_back('{"wr_d0_alias",  0, 1'b0, 1'b1, 32'h0000_4003, 32'h0001_0000, 0,   0,   512});
        vt.push_back('{"rd_d0_alias",  0, 1'b1, 1'b0, 3,            16,           512, 512, 0});

        repeat (3) @(negedge clk_sys);
        check("reset_outs", {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
                             mem_rd, mem_wr, mem_addr, mem_din}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        max_lat = 0;
        foreach (vt[k]) begin
            run_sector(vt[k].name, vt[k].drv, vt[k].rd, vt[k].wr, vt[k].lba, vt[k].blk,
                       vt[k].e_strb, vt[k].e_rd, vt[k].e_wr, len);
            if (vt[k].rd && vt[k].e_rd == 512)
                check({vt[k].name, ".rate"}, (len >= 1536 && len <= 1540), 1);
        end

        // Multi-sector track load: rd held, lba bumped on every ack rise.
        strb.delete();
        rd_done = 0;
        pulses  = 0;
        min_gap = 1000;
        ok_all  = 1'b1;
        @(negedge clk_sys);
        img_blocks[31:0] = 16;
        sd_lba[31:0]     = 0;
        sd_rd[0]         = 1'b1;
        for (int k = 0; k < 13; k++) begin
            wait_ack(0, 1'b1, 20, cyc, ok);
            if (ok) pulses++;
            else ok_all = 1'b0;
            if (k > 0 && cyc < min_gap) min_gap = cyc;
            sd_lba[31:0] = k + 1;
            if (k == 12) sd_rd[0] = 1'b0;
            wait_ack(0, 1'b0, 4000, cyc, ok);
            if (!ok) ok_all = 1'b0;
        end
        repeat (3) @(negedge clk_sys);
        check("fdd.pulses", pulses, 13);
        check("fdd.no_timeout", ok_all, 1);
        check("fdd.min_gap_ge2", (min_gap >= 2), 1);
        check("fdd.strobes", strb.size(), 13 * 512);
        check("fdd.mem_reads", rd_done, 13 * 512);
        bad = 0;
        for (int k = 0; k < 13; k++) bad += rd_bad(k * 512, 0, k, 1'b0);
        check("fdd.data_order", bad, 0);

        // Simultaneous requests with pointer at drive 0: drive 1 first.
        strb.delete();
        @(negedge clk_sys);
        sd_lba[31:0]  = 1;
        sd_lba[63:32] = 2;
        img_blocks    = {32'd16, 32'd16};
        sd_rd         = 2'b11;
        @(negedge clk_sys);
        check("arb.first", sd_ack, 2'b10);
        sd_rd[1] = 1'b0;
        wait_ack(1, 1'b0, 4000, cyc, ok);
        wait_ack(0, 1'b1, 20, cyc, ok);
        check("arb.second_granted", ok, 1);
        check("arb.second", sd_ack, 2'b01);
        sd_rd[0] = 1'b0;
        wait_ack(0, 1'b0, 4000, cyc, ok);
        repeat (3) @(negedge clk_sys);
        check("arb.strobes", strb.size(), 1024);
        check("arb.data", rd_bad(0, 1, 2, 1'b0) + rd_bad(512, 0, 1, 1'b0), 0);

        // rd and wr together on one drive: read is served, write stays pending.
        strb.delete();
        wlog.delete();
        wpat[1] = 8'h5A;
        @(negedge clk_sys);
        sd_lba[63:32] = 9;
        sd_rd[1] = 1'b1;
        sd_wr[1] = 1'b1;
        @(negedge clk_sys);
        check("rdwr.ack", sd_ack, 2'b10);
        sd_rd[1] = 1'b0;
        wait_ack(1, 1'b0, 4000, cyc, ok);
        check("rdwr.read_strobes", strb.size(), 512);
        check("rdwr.read_no_wr", wlog.size(), 0);
        check("rdwr.read_data", rd_bad(0, 1, 9, 1'b0), 0);
        wait_ack(1, 1'b1, 20, cyc, ok);
        check("rdwr.write_granted", ok, 1);
        sd_wr[1] = 1'b0;
        wait_ack(1, 1'b0, 4000, cyc, ok);
        repeat (3) @(negedge clk_sys);
        check("rdwr.write_count", wlog.size(), 512);
        check("rdwr.write_no_strobe", strb.size(), 512);
        check("rdwr.write_log", wlog_bad(1, 9), 0);
        ref_write(1, 9);

        // Random sectors with variable memory latency.
        max_lat = 2;
        for (int k = 0; k < 4; k++) begin
            int drv;
            bit rd, oor;
            int unsigned lba, blk;
            drv = int'($urandom_range(1));
            rd  = 1'($urandom_range(1));
            lba = $urandom_range(20);
            blk = ($urandom_range(1) == 1) ? 16 : $urandom_range(24);
            wpat[drv] = 8'($urandom);
            oor = (lba >= blk);
            run_sector($sformatf("rand%0d", k), drv, rd, !rd, lba, blk,
                       rd ? 512 : 0, (rd && !oor) ? 512 : 0, (!rd && !oor) ? 512 : 0, len);
        end

        // Reset in the middle of a read, with mem_rd outstanding.
        @(negedge clk_sys);
        sd_lba[31:0]     = 4;
        img_blocks[31:0] = 16;
        sd_rd[0]         = 1'b1;
        @(negedge clk_sys);
        sd_rd[0] = 1'b0;
        found = 0;
        for (int c = 0; c < 4000; c++) begin
            if (sd_buff_addr == 9'd200 && mem_rd) begin
                found = 1;
                break;
            end
            @(negedge clk_sys);
        end
        check("rst.reached_byte200", found, 1);
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("rst.mem_rd", mem_rd, 0);
        check("rst.sd_ack", sd_ack, 0);
        check("rst.all_outs", {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
                               mem_rd, mem_wr, mem_addr, mem_din}, 0);
        strb.delete();
        rd_done = 0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        check("rst.no_strobes", strb.size(), 0);
        check("rst.no_reads", rd_done, 0);
        check("rst.ack_idle", sd_ack, 0);
        run_sector("rd_after_rst", 0, 1'b1, 1'b0, 4, 16, 512, 512, 0, len);

        check("ack_onehot", multi_ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_block_responder.md
Name: sd_block_responder

Overview:
- Target (responder) side of the virtual-disk sector protocol used by the disk loaders: sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*.
- Serves 512-byte sector reads and writes for up to VDNUM drives from a byte-wide backing store (BRAM or SDRAM controller port), so an image can be served on-chip without the HPS.
- Sits between the FDD/HDD request logic and a memory arbiter port.

Parameters:
VDNUM, 2, number of drives served (1..4); DEVW = max(1, clog2(VDNUM)).
MEM_AW, 24, byte address width of backing store; each drive owns a 2^(MEM_AW-DEVW)-byte region.

Ports:
clk_sys  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
sd_lba  in  32*VDNUM  sector number per drive; drive n = bits [32n+31:32n].
sd_rd  in  VDNUM  read request per drive, level.
sd_wr  in  VDNUM  write request per drive, level.
sd_ack  out  VDNUM  transfer-in-progress per drive; at most one bit high.
sd_buff_addr  out  9  byte index within sector.
sd_buff_dout  out  8  read data to initiator buffer.
sd_buff_din  in  8*VDNUM  write data from initiator buffer; registered, valid 1 cycle after sd_buff_addr.
sd_buff_wr  out  1  one-cycle strobe, read data valid.
img_blocks  in  32*VDNUM  image size in sectors per drive; 0 = unmounted.
mem_addr  out  MEM_AW  {drive[DEVW-1:0], lba[MEM_AW-DEVW-10:0], byte[8:0]}.
mem_rd  out  1  read request, held until mem_ready.
mem_wr  out  1  write request, held until mem_ready.
mem_din  out  8  write data to store.
mem_dout  in  8  read data, valid when mem_ready.
mem_ready  in  1  one-cycle completion pulse.

Behaviour:
- Reset (async, reset_n=0): state IDLE; sd_ack=0, sd_buff_addr=0, sd_buff_dout=0, sd_buff_wr=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_din=0, round-robin pointer=0.
- Reset mid-transfer abandons the sector: no further strobes, memory request dropped immediately; the memory port must tolerate a dropped request.
- States: IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_CAP, WR_REQ, DONE, GAP.
- IDLE, drive grant:
  - Grant the first drive with rd|wr, scanning from pointer+1 modulo VDNUM. Pointer := granted drive.
  - Latch drive, op and sd_lba[n]. Set sd_ack[n]=1 on the next edge; sd_buff_addr=0.
  - rd and wr both high on one drive: read wins; the write stays pending.
  - oor := (lba >= img_blocks[n]).
- Read path:
  - RD_REQ: if oor, take data = 0 with no memory access. Else assert mem_rd with mem_addr for the current byte and wait for mem_ready.
  - On data: sd_buff_dout := data; go to RD_PUT.
  - RD_PUT: sd_buff_wr=1 for exactly one cycle; sd_buff_addr and sd_buff_dout are stable in that cycle and stay held until the next byte.
  - After RD_PUT: if byte=511 go to DONE, else sd_buff_addr+1 and return to RD_REQ.
  - Minimum rate (in-range read): 3 cycles/byte with mem_ready on the first request cycle.
- Write path:
  - WR_ADDR: drive sd_buff_addr.
  - WR_CAP: one cycle later, capture sd_buff_din[drive] into mem_din.
  - WR_REQ: assert mem_wr until mem_ready; if oor, skip the store (no mem_wr). Then advance the byte or go to DONE after 511.
  - sd_buff_wr stays 0 throughout a write.
- DONE: sd_ack[n] := 0.
- GAP: one cycle with sd_ack=0, then IDLE. Guarantees ack is low for ≥2 cycles, so initiators' edge detectors see both edges.
- Back-to-back sectors: an initiator holding sd_rd high across sectors (multi-sector track load) receives consecutive ack pulses. sd_lba is resampled at each grant, so the initiator may change it on the ack rising edge.
- Request removal: requests deasserted while ack is high do not abort the sector; all 512 bytes always complete.
- Byte counter: 9 bits and wraps only via DONE. lba bits above the drive region are ignored for addressing; the oor check still uses the full 32 bits.
- img_blocks is sampled only at grant.

Test Plan:
1. Drive0 img_blocks=16, store preloaded with byte=addr[7:0]^lba; sd_rd=01, lba=3 -> sd_ack[0] high 1 cycle after request; 512 sd_buff_wr strobes with addr 0..511, dout = (addr&FF)^3; ack falls; 0 memory writes.
2. Drive1 sd_wr, lba=5, initiator buffer = 0xA5^addr -> 512 mem_wr at addresses {1,5,0..511} with matching data; sd_buff_wr never asserted.
3. Drive0 lba=20, img_blocks=16: read -> 512 strobes of 0x00 and no mem_rd; write -> no mem_wr, full ack pulse.
4. sd_rd held high for 13 sectors, initiator increments lba on each ack rise (FDD pattern) -> 13 ack pulses, each separated by ≥2 low cycles, lbas 0..12 served in order.
5. Both drives request in the same cycle, pointer=0 -> drive1 served first, then drive0; one sd_ack bit high at a time; rd+wr on the same drive -> read first.
6. reset_n low at byte 200 of a read, while mem_rd is pending -> all outputs 0 asynchronously; after release, a new request restarts at sd_buff_addr=0.
